// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic lamp side: head states, monitor fault codes
// and monitor FSM states.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED = 2'd0,
    YEL = 2'd1,
    GRN = 2'd2,
    BAD = 2'd3
  } head_t;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_CONFLICT     = 3'd1;
  localparam logic [2:0] FC_MAIN_BAD     = 3'd2;
  localparam logic [2:0] FC_SIDE_BAD     = 3'd3;
  localparam logic [2:0] FC_MAIN_ILLEGAL = 3'd4;
  localparam logic [2:0] FC_SIDE_ILLEGAL = 3'd5;
  localparam logic [2:0] FC_MAIN_YSHORT  = 3'd6;
  localparam logic [2:0] FC_SIDE_YSHORT  = 3'd7;

  localparam logic [1:0] MON_OK    = 2'd0;
  localparam logic [1:0] MON_PEND  = 2'd1;
  localparam logic [1:0] MON_FAULT = 2'd2;

endpackage

// File: rtl/lamp_head_checker.sv
// One signal head: decodes the three lamps, remembers last cycle's state and
// times the yellow phase, flagging malformed heads, illegal steps and short yellows.
module lamp_head_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic grn,
  input  logic yel,
  input  logic red,
  output logic is_bad,
  output logic illegal,
  output logic yshort
);

  head_t            cur;
  head_t            prev;
  logic [CNT_W-1:0] dwell;
  logic             checkable;
  logic             legal_step;

  always_comb begin
    cur = BAD;
    case ({grn, yel, red})
      3'b001:  cur = RED;
      3'b010:  cur = YEL;
      3'b100:  cur = GRN;
      default: cur = BAD;
    endcase
  end

  // Sequence checks are meaningless when either end of the step is malformed.
  assign checkable  = (cur != BAD) && (prev != BAD);
  assign legal_step = (prev == cur)
                   || ((prev == GRN) && (cur == YEL))
                   || ((prev == YEL) && (cur == RED))
                   || ((prev == RED) && (cur == GRN));

  assign is_bad  = (cur == BAD);
  assign illegal = checkable && !legal_step;
  assign yshort  = checkable && (prev == YEL) && (cur == RED)
                && (dwell < CNT_W'(MIN_YELLOW));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= RED;
      dwell <= '0;
    end else begin
      prev <= cur;
      if (cur == YEL) begin
        if (prev != YEL)
          dwell <= CNT_W'(1);
        else if (dwell != '1)
          dwell <= dwell + 1'b1;
      end else begin
        dwell <= '0;
      end
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Conflict monitor on the lamp outputs: filters level violations, latches the
// first fault by priority and drives the all-red flash enable while latched.
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int FILTER     = 2,
  parameter int FLASH_HALF = 5,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       MG,
  input  logic       MY,
  input  logic       MR,
  input  logic       SG,
  input  logic       SY,
  input  logic       SR,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash,
  output logic       viol
);

  localparam int FILT_W = 4;

  logic              main_bad, main_ill, main_ys;
  logic              side_bad, side_ill, side_ys;
  logic              conflict, level, event_any, level_done;
  logic [7:0]        qual;
  logic [1:0]        state, state_nx;
  logic [FILT_W-1:0] filt_cnt, filt_nx;
  logic [2:0]        code_nx;
  logic [CNT_W-1:0]  flash_cnt;

  function automatic logic [2:0] pick_code(input logic [7:0] q);
    logic [2:0] c;
    c = FC_NONE;
    for (int i = 7; i >= 0; i--)
      if (q[i]) c = 3'(i);
    return c;
  endfunction

  lamp_head_checker #(.MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .grn     (MG),
    .yel     (MY),
    .red     (MR),
    .is_bad  (main_bad),
    .illegal (main_ill),
    .yshort  (main_ys)
  );

  lamp_head_checker #(.MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_side (
    .clk     (clk),
    .rst     (rst),
    .grn     (SG),
    .yel     (SY),
    .red     (SR),
    .is_bad  (side_bad),
    .illegal (side_ill),
    .yshort  (side_ys)
  );

  assign conflict   = (MG | MY) & (SG | SY);
  assign level      = conflict | main_bad | side_bad;
  assign event_any  = main_ill | side_ill | main_ys | side_ys;
  assign viol       = level | event_any;
  assign level_done = level && ((filt_cnt + FILT_W'(1)) >= FILT_W'(FILTER));

  // Level codes only compete once the filter has run its course this cycle.
  always_comb begin
    qual                  = '0;
    qual[FC_CONFLICT]     = level_done & conflict;
    qual[FC_MAIN_BAD]     = level_done & main_bad;
    qual[FC_SIDE_BAD]     = level_done & side_bad;
    qual[FC_MAIN_ILLEGAL] = main_ill;
    qual[FC_SIDE_ILLEGAL] = side_ill;
    qual[FC_MAIN_YSHORT]  = main_ys;
    qual[FC_SIDE_YSHORT]  = side_ys;
  end

  always_comb begin
    state_nx = state;
    filt_nx  = filt_cnt;
    code_nx  = fault_code;
    case (state)
      MON_OK, MON_PEND: begin
        if (qual != '0) begin
          state_nx = MON_FAULT;
          filt_nx  = '0;
          code_nx  = pick_code(qual);
        end else if (level) begin
          state_nx = MON_PEND;
          filt_nx  = filt_cnt + FILT_W'(1);
        end else begin
          state_nx = MON_OK;
          filt_nx  = '0;
        end
      end
      MON_FAULT: begin
        if (clr_fault && !viol) begin
          state_nx = MON_OK;
          code_nx  = FC_NONE;
        end
      end
      default: begin
        state_nx = MON_OK;
        filt_nx  = '0;
        code_nx  = FC_NONE;
      end
    endcase
  end

  assign fault = (state == MON_FAULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MON_OK;
      filt_cnt   <= '0;
      fault_code <= FC_NONE;
      flash      <= 1'b0;
      flash_cnt  <= '0;
    end else begin
      state      <= state_nx;
      filt_cnt   <= filt_nx;
      fault_code <= code_nx;
      if (state_nx == MON_FAULT) begin
        if (state != MON_FAULT) begin
          flash     <= 1'b1;
          flash_cnt <= '0;
        end else if (flash_cnt >= CNT_W'(FLASH_HALF - 1)) begin
          flash     <= ~flash;
          flash_cnt <= '0;
        end else if (flash_cnt != '1) begin
          flash_cnt <= flash_cnt + 1'b1;
        end
      end else begin
        flash     <= 1'b0;
        flash_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: directed scenarios plus randomized lamps
// checked against a rule-level model of the monitor.
module tb_traffic_lamp_monitor;

  localparam int MIN_YELLOW = 3;
  localparam int FILTER     = 2;
  localparam int FLASH_HALF = 5;
  localparam int CNT_W      = 8;
  localparam int DWELL_MAX  = (1 << CNT_W) - 1;

  // {MG,MY,MR,SG,SY,SR}
  localparam logic [5:0] P_GR = 6'b100_001;
  localparam logic [5:0] P_YR = 6'b010_001;
  localparam logic [5:0] P_RR = 6'b001_001;
  localparam logic [5:0] P_RG = 6'b001_100;
  localparam logic [5:0] P_RY = 6'b001_010;
  localparam logic [5:0] P_GG = 6'b100_100;
  localparam logic [5:0] P_GY = 6'b100_010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       MG = 0, MY = 0, MR = 1, SG = 0, SY = 0, SR = 1, clr_fault = 0;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
  logic       viol;

  int checks = 0;
  int errors = 0;

  // Reference model state: heads as 0=red 1=yellow 2=green 3=malformed
  int mp, sp, mdw, sdw, streak, since, mcode;
  bit mf;

  traffic_lamp_monitor #(
    .MIN_YELLOW(MIN_YELLOW), .FILTER(FILTER), .FLASH_HALF(FLASH_HALF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .MG(MG), .MY(MY), .MR(MR), .SG(SG), .SY(SY), .SR(SR),
    .clr_fault(clr_fault),
    .fault(fault), .fault_code(fault_code), .flash(flash), .viol(viol)
  );

  always #5 clk = ~clk;

  function automatic int head(input logic g, input logic y, input logic r);
    case ({g, y, r})
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  // Legal progression is red -> green -> yellow -> red, or staying put.
  function automatic bit legal(input int p, input int c);
    return (p == c) || (c == (p + 2) % 3);
  endfunction

  function automatic int lvl_code();
    int hm = head(MG, MY, MR);
    int hs = head(SG, SY, SR);
    if ((MG | MY) && (SG | SY)) return 1;
    if (hm == 3) return 2;
    if (hs == 3) return 3;
    return 0;
  endfunction

  function automatic int ev_code();
    int hm = head(MG, MY, MR);
    int hs = head(SG, SY, SR);
    if (mp != 3 && hm != 3 && !legal(mp, hm)) return 4;
    if (sp != 3 && hs != 3 && !legal(sp, hs)) return 5;
    if (mp == 1 && hm == 0 && mdw < MIN_YELLOW) return 6;
    if (sp == 1 && hs == 0 && sdw < MIN_YELLOW) return 7;
    return 0;
  endfunction

  function automatic bit mdl_viol();
    return (lvl_code() != 0) || (ev_code() != 0);
  endfunction

  function automatic bit mdl_flash();
    return mf && (((since / FLASH_HALF) % 2) == 0);
  endfunction

  task automatic model_reset();
    mp = 0; sp = 0; mdw = 0; sdw = 0; streak = 0; since = 0; mcode = 0; mf = 0;
  endtask

  task automatic apply(input logic [5:0] p, input logic c);
    {MG, MY, MR, SG, SY, SR} = p;
    clr_fault = c;
    #1;
  endtask

  // Advance one clock and move the model by the same cycle's inputs.
  task automatic tick();
    int lc = lvl_code();
    int ec = ev_code();
    bit v  = (lc != 0) || (ec != 0);
    int hm = head(MG, MY, MR);
    int hs = head(SG, SY, SR);
    bit c  = clr_fault;
    @(posedge clk);
    #1;
    if (!mf) begin
      int code;
      streak = (lc != 0) ? streak + 1 : 0;
      code   = (lc != 0 && streak >= FILTER) ? lc : ec;
      if (code != 0) begin
        mf = 1; mcode = code; since = 0; streak = 0;
      end
    end else if (c && !v) begin
      mf = 0; mcode = 0;
    end else begin
      since++;
    end
    mdw = (hm == 1) ? ((mp == 1) ? ((mdw < DWELL_MAX) ? mdw + 1 : DWELL_MAX) : 1) : 0;
    sdw = (hs == 1) ? ((sp == 1) ? ((sdw < DWELL_MAX) ? sdw + 1 : DWELL_MAX) : 1) : 0;
    mp = hm;
    sp = hs;
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst = 1'b0;
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b want 0", fault); end
    checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", fault_code); end
    checks++; if (flash !== 1'b0) begin errors++; $display("FAIL reset_flash: got %0b want 0", flash); end
    apply(P_GG, 1'b0);
    checks++; if (viol !== 1'b1) begin errors++; $display("FAIL reset_viol_comb: got %0b want 1", viol); end
    apply(P_RR, 1'b0);
    checks++; if (viol !== 1'b0) begin errors++; $display("FAIL reset_viol_idle: got %0b want 0", viol); end
    @(negedge clk);
    rst = 1'b1;
    apply(P_RR, 1'b0);
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_release: fault=%0b want 0", fault); end
  endtask

  task automatic test_legal_cycle();
    logic [5:0] seq[$];
    for (int i = 0; i < 10; i++) seq.push_back(P_GR);
    for (int i = 0; i < 3; i++) seq.push_back(P_YR);
    for (int i = 0; i < 2; i++) seq.push_back(P_RR);
    for (int i = 0; i < 4; i++) seq.push_back(P_RG);
    for (int i = 0; i < 3; i++) seq.push_back(P_RY);
    for (int i = 0; i < 2; i++) seq.push_back(P_RR);
    foreach (seq[k]) begin
      apply(seq[k], 1'b0);
      checks++; if (viol !== 1'b0) begin errors++; $display("FAIL legal_viol step %0d: got %0b want 0", k, viol); end
      tick();
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL legal_fault step %0d: got %0b want 0", k, fault); end
    end
  endtask

  task automatic test_conflict_pulse();
    apply(P_GR, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin apply(P_YR, 1'b0); tick(); end
    apply(6'b010_100, 1'b0);
    checks++; if (viol !== 1'b1) begin errors++; $display("FAIL pulse_viol: got %0b want 1", viol); end
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL pulse_fault: got %0b want 0", fault); end
    apply(P_RG, 1'b0);
    checks++; if (viol !== 1'b0) begin errors++; $display("FAIL pulse_after_viol: got %0b want 0", viol); end
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL pulse_after_fault: got %0b want 0", fault); end
  endtask

  task automatic test_conflict_fault();
    apply(P_GG, 1'b0); tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL conflict_first: fault=%0b want 0", fault); end
    apply(P_GG, 1'b0); tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL conflict_fault: got %0b want 1", fault); end
    checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL conflict_code: got %0d want 1", fault_code); end
    checks++; if (flash !== 1'b1) begin errors++; $display("FAIL conflict_flash0: got %0b want 1", flash); end
    for (int k = 1; k < 10; k++) begin
      apply(P_GG, 1'b0); tick();
      checks++;
      if (flash !== ((k < FLASH_HALF) ? 1'b1 : 1'b0))
        begin errors++; $display("FAIL flash_step %0d: got %0b want %0b", k, flash, (k < FLASH_HALF)); end
      checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL code_frozen %0d: got %0d want 1", k, fault_code); end
    end
    apply(P_GG, 1'b1); tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL clear_ignored: fault=%0b want 1", fault); end
    for (int i = 0; i < 3; i++) begin
      apply(P_GY, 1'b0); tick();
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL clear_not_kept %0d: fault=%0b want 1", i, fault); end
    end
    apply(P_GR, 1'b1);
    checks++; if (viol !== 1'b0) begin errors++; $display("FAIL clear_viol: got %0b want 0", viol); end
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL clear_fault: got %0b want 0", fault); end
    checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL clear_code: got %0d want 0", fault_code); end
    checks++; if (flash !== 1'b0) begin errors++; $display("FAIL clear_flash: got %0b want 0", flash); end
  endtask

  task automatic test_illegal_and_short();
    apply(P_RR, 1'b0);
    checks++; if (viol !== 1'b1) begin errors++; $display("FAIL illegal_viol: got %0b want 1", viol); end
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL illegal_fault: got %0b want 1", fault); end
    checks++; if (fault_code !== 3'd4) begin errors++; $display("FAIL illegal_code: got %0d want 4", fault_code); end
    apply(P_RR, 1'b1); tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL illegal_clear: fault=%0b want 0", fault); end
    apply(P_RR, 1'b1); tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL clr_outside_fault: fault=%0b want 0", fault); end
    apply(P_GR, 1'b0); tick();
    apply(P_YR, 1'b0); tick();
    apply(P_YR, 1'b0); tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL yshort_pre: fault=%0b want 0", fault); end
    apply(P_RR, 1'b0); tick();
    checks++; if (fault_code !== 3'd6) begin errors++; $display("FAIL yshort_code: got %0d want 6", fault_code); end
    apply(P_RR, 1'b1); tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL yshort_clear: fault=%0b want 0", fault); end
  endtask

  task automatic test_bad_and_conflict();
    apply(6'b011_100, 1'b0); tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL badconf_first: fault=%0b want 0", fault); end
    apply(6'b011_100, 1'b0); tick();
    checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL badconf_code: got %0d want 1", fault_code); end
    apply(P_RG, 1'b1);
    checks++; if (viol !== 1'b0) begin errors++; $display("FAIL badconf_recover_viol: got %0b want 0", viol); end
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL badconf_clear: fault=%0b want 0", fault); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin apply(P_GG, 1'b0); tick(); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL areset_pre: fault=%0b want 1", fault); end
    #2 rst = 1'b0;
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL areset_fault: got %0b want 0", fault); end
    checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL areset_code: got %0d want 0", fault_code); end
    checks++; if (flash !== 1'b0) begin errors++; $display("FAIL areset_flash: got %0b want 0", flash); end
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      apply(P_GR, 1'b0);
      checks++; if (viol !== 1'b0) begin errors++; $display("FAIL areset_after_viol %0d: got %0b want 0", i, viol); end
      tick();
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL areset_after_fault %0d: got %0b want 0", i, fault); end
    end
  endtask

  task automatic test_random();
    int ms = 2, ss = 0;
    for (int n = 0; n < 400; n++) begin
      logic [2:0] mh, sh;
      if ($urandom_range(0, 9) >= 7) ms = $urandom_range(0, 2);
      if ($urandom_range(0, 9) >= 7) ss = $urandom_range(0, 2);
      mh = (ms == 0) ? 3'b001 : (ms == 1) ? 3'b010 : 3'b100;
      sh = (ss == 0) ? 3'b001 : (ss == 1) ? 3'b010 : 3'b100;
      if ($urandom_range(0, 19) == 0) mh = 3'($urandom);
      if ($urandom_range(0, 19) == 0) sh = 3'($urandom);
      apply({mh[2], mh[1], mh[0], sh[2], sh[1], sh[0]}, ($urandom_range(0, 3) == 0));
      checks++; if (viol !== mdl_viol()) begin errors++; $display("FAIL rand_viol %0d: got %0b want %0b", n, viol, mdl_viol()); end
      tick();
      checks++; if (fault !== mf) begin errors++; $display("FAIL rand_fault %0d: got %0b want %0b", n, fault, mf); end
      checks++; if (fault_code !== 3'(mcode)) begin errors++; $display("FAIL rand_code %0d: got %0d want %0d", n, fault_code, mcode); end
      checks++; if (flash !== mdl_flash()) begin errors++; $display("FAIL rand_flash %0d: got %0b want %0b", n, flash, mdl_flash()); end
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict_pulse();
    test_conflict_fault();
    test_illegal_and_short();
    test_bad_and_conflict();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_monitor.md
# traffic_lamp_monitor

Independent conflict monitor on the lamp side of `trafficSignalController`. It consumes the six lamp outputs (MG, MY, MR, SG, SY, SR), checks them every clock for conflicting greens, malformed lamp heads, illegal sequences and short yellows, then latches a fault. While the fault is latched it drives a flash enable that the lamp driver uses to force all-red flashing. This block is the reader of the lamp interface that the controller writes.

## Interface
Parameters:
- MIN_YELLOW, 3: minimum number of cycles a head must stay yellow before going red.
- FILTER, 2: number of consecutive cycles a level violation must persist before it latches (1..15).
- FLASH_HALF, 5: flash half-period, in cycles.
- CNT_W, 8: width of the dwell and flash counters. Counters saturate at all-ones.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (port keeps the codebase name `rst`; asserted when 0).
- MG, MY, MR  in  1 each  main-road green, yellow and red lamps.
- SG, SY, SR  in  1 each  side-road green, yellow and red lamps.
- clr_fault  in  1  single-cycle request to clear a latched fault.
- fault  out  1  latched fault indication.
- fault_code  out  3  code of the first latched fault; 0 when no fault.
- flash  out  1  flash enable; valid only while `fault` is 1.
- viol  out  1  combinational: some violation is present in the current cycle (unfiltered).

## Operation
- Each head (main, side) is decoded to RED, YEL, GRN or BAD. BAD means the lamp pattern is not one-hot.
- Previous head state registers reset to RED, and update every cycle with the decoded state. BAD is stored as BAD.
- Yellow dwell counter, one per head:
  - loads 1 on entry to YEL;
  - increments while the head stays in YEL;
  - clears in any other state.
- Level violations are filtered. Each must be present for FILTER consecutive cycles; one shared counter tracks them and clears on any cycle with no level violation.
  - Code 1, conflict: (MG|MY) and (SG|SY) are both true.
  - Code 2: main head is BAD.
  - Code 3: side head is BAD.
- Event violations latch with no filter. They are evaluated only when both the previous and current states are not BAD.
  - Code 4: main head makes an illegal transition.
  - Code 5: side head makes an illegal transition.
  - Code 6: main head goes YEL→RED with dwell < MIN_YELLOW.
  - Code 7: side head goes YEL→RED with dwell < MIN_YELLOW.
- Legal transitions: GRN→YEL, YEL→RED, RED→GRN, and staying in the same state. All others are illegal (GRN→RED, RED→YEL, YEL→GRN).
- Priority when several violations qualify on the same edge: the lowest code wins.
- Monitor FSM:
  - MON_OK: no fault and filter counter at 0.
  - MON_PEND: a level violation is seen and the filter is counting. Returns to MON_OK if the violation disappears.
  - MON_FAULT: fault latched.
- In MON_FAULT:
  - `fault_code` is frozen; later violations never overwrite it.
  - Lamp tracking continues.
  - `flash` toggles every FLASH_HALF cycles, starting at 1 on entry.
- Clearing a fault:
  - `clr_fault` exits MON_FAULT to MON_OK only if `viol` is 0 in the same cycle.
  - If `viol` is 1, the request is ignored and is not remembered.
  - `clr_fault` outside MON_FAULT has no effect.

## Timing
- Reset values: fault=0, fault_code=0, flash=0, both previous states RED, dwell counters 0, filter counter 0, flash counter 0, FSM in MON_OK. `viol` follows the inputs combinationally even during reset.
- Level fault latency: `fault` rises on the edge that closes the FILTER-th consecutive violating cycle. With FILTER=2, violating cycles N and N+1 give `fault` high after edge N+1.
- Event fault latency: `fault` and `fault_code` are registered on the edge that closes the cycle in which the transition is seen.
- Clear latency: with a qualifying `clr_fault` in cycle N, fault, fault_code and flash are all 0 after edge N.
- Flash timing: flash is 1 for FLASH_HALF cycles, then 0 for FLASH_HALF cycles, and repeats. The flash counter restarts on every entry to MON_FAULT.
- Reset mid-fault: everything returns asynchronously to reset values. The first edge after release treats previous states as RED, so RED→GRN is legal.
- Dwell counter saturation at 2^CNT_W−1 is never a violation.

## Structure
- Shared package `traffic_pkg` holds:
  - the head-state encoding: RED=2'd0, YEL=2'd1, GRN=2'd2, BAD=2'd3;
  - the fault-code constants FC_NONE through FC_SIDE_YSHORT (0–7);
  - the monitor FSM state encoding.
- Sub-module `lamp_head_checker` is instantiated twice, once per head. It contains the decode, the previous-state register and the dwell counter, and outputs the BAD, illegal-transition and yellow-short flags.
- The top level contains the filter, priority encoder, FSM and flash counter.

## Test plan
- Legal cycle with MIN_YELLOW=3: main goes GRN for 10 cycles, YEL for 3, RED; side goes RED→GRN after main is RED → fault stays 0 and viol stays 0 throughout.
- MG=1 and SG=1 for 1 cycle, then legal → viol pulses, fault stays 0. Held for 2 cycles → fault=1, fault_code=1, flash=1 for 5 cycles then 0 for 5.
- Main GRN→RED directly → fault=1 and fault_code=4 one edge later. Main YEL for 2 cycles then RED → fault_code=6.
- MR=1 and MY=1 for 2 cycles while SG=1 → conflict and BAD qualify together → fault_code=1.
- In fault, clr_fault pulsed while the conflict persists → fault remains 1. Pulsed after lamps are legal → fault=0, fault_code=0 and flash=0 after that edge.
- rst driven low mid-flash for 1 ns, asynchronous to clk → outputs 0 immediately. After release, lamps with MG=1 and SR=1 → no fault.
